calc_exec: RTL and testbench

Execution back-end of the calculator. Consumes the operand pair and ready flag produced by the operand-entry FSM, performs add, subtract, multiply or divide on the 6-bit unsigned operands, and converts the result to four BCD digits for the display drivers. The flag from the entry FSM is treated as asynchronous to the system clock.

---
 rtl/calc_exec.sv | 203 ++++++++++++++++++++
 tb/tb_calc_exec.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_exec.sv
// ---------------------------------------------------------------------------
// calc_exec : calculator back-end (add/sub/mul/div on 6-bit operands + BCD)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module calc_exec (
  input  logic        clk,
  input  logic        resetN,
  input  logic        flag,
  input  logic [5:0]  A,
  input  logic [5:0]  B,
  input  logic [1:0]  opcode,
  output logic [11:0] result,
  output logic        neg,
  output logic [5:0]  rem,
  output logic        err,
  output logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic        valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MUL = 2'b10;
  localparam logic [1:0] c_OP_DIV = 2'b11;

  state_t      r_state;
  logic        r_s1, r_s2, r_s3;
  logic [1:0]  r_op;
  logic [5:0]  r_a;      // dividend shifts out MSB-first, quotient shifts in
  logic [5:0]  r_b;      // multiplier shifts out LSB-first
  logic [11:0] r_mcand;
  logic [11:0] r_res;
  logic [5:0]  r_prem;
  logic        r_neg;
  logic        r_err;
  logic [3:0]  r_cnt;
  logic [27:0] r_dd;     // {bcd[15:0], binary[11:0]}

  logic        w_start;
  logic [6:0]  w_sum7;
  logic        w_ge;
  logic [5:0]  w_diff;
  logic [11:0] w_acc_nxt;
  logic [6:0]  w_trial;
  logic        w_qbit;
  logic [5:0]  w_sub;
  logic [5:0]  w_prem_nxt;
  logic [5:0]  w_quo_nxt;
  logic        w_divz;
  logic        w_last;
  logic [11:0] w_res;
  logic [15:0] w_adj;
  logic [27:0] w_dd_nxt;

  assign w_start   = r_s2 & ~r_s3;
  assign w_sum7    = {1'b0, r_a} + {1'b0, r_b};
  assign w_ge      = (r_a >= r_b);
  assign w_diff    = w_ge ? (r_a - r_b) : (r_b - r_a);
  assign w_acc_nxt = r_res + (r_b[0] ? r_mcand : 12'd0);

  // Restoring division step: partial remainder always fits 6 bits after restore.
  assign w_trial    = {r_prem, r_a[5]};
  assign w_qbit     = (w_trial >= {1'b0, r_b});
  assign w_sub      = w_trial[5:0] - r_b;
  assign w_prem_nxt = w_qbit ? w_sub : w_trial[5:0];
  assign w_quo_nxt  = {r_a[4:0], w_qbit};
  assign w_divz     = (r_b == 6'd0);

  assign w_last = (r_op[1] == 1'b0) || ((r_op == c_OP_DIV) && w_divz) || (r_cnt == 4'd5);

  always_comb begin
    w_res = 12'd0;
    case (r_op)
      2'b00:    w_res = {5'd0, w_sum7};
      c_OP_SUB: w_res = {6'd0, w_diff};
      c_OP_MUL: w_res = w_acc_nxt;
      c_OP_DIV: w_res = w_divz ? 12'd0 : {6'd0, w_quo_nxt};
      default:  w_res = 12'd0;
    endcase
  end

  // Double-dabble: correct each BCD nibble, then shift the whole register left.
  always_comb begin
    w_adj = r_dd[27:12];
    for (int i = 0; i < 4; i++) begin
      if (r_dd[12 + 4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_dd[12 + 4*i +: 4] + 4'd3;
    end
  end

  assign w_dd_nxt = {w_adj, r_dd[11:0]} << 1;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_op    <= 2'd0;
      r_a     <= 6'd0;
      r_b     <= 6'd0;
      r_mcand <= 12'd0;
      r_res   <= 12'd0;
      r_prem  <= 6'd0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= 4'd0;
      r_dd    <= 28'd0;
      result  <= 12'd0;
      neg     <= 1'b0;
      rem     <= 6'd0;
      err     <= 1'b0;
      bcd     <= 16'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      r_s1 <= flag;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= opcode;
            r_mcand <= {6'd0, A};
            r_res   <= 12'd0;
            r_prem  <= 6'd0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 4'd0;
            valid   <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_EXEC;
          end
        end

        S_EXEC: begin
          r_cnt <= r_cnt + 4'd1;
          r_res <= w_res;
          case (r_op)
            c_OP_SUB: r_neg <= ~w_ge;
            c_OP_MUL: begin
              r_mcand <= r_mcand << 1;
              r_b     <= {1'b0, r_b[5:1]};
            end
            c_OP_DIV: begin
              if (w_divz) begin
                r_err <= 1'b1;
              end else begin
                r_prem <= w_prem_nxt;
                r_a    <= w_quo_nxt;
              end
            end
            default: ;
          endcase
          if (w_last) begin
            r_cnt   <= 4'd0;
            r_dd    <= {16'd0, w_res};
            r_state <= S_CONV;
          end
        end

        S_CONV: begin
          r_dd  <= w_dd_nxt;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd11) begin
            result  <= r_res;
            neg     <= r_neg;
            rem     <= r_prem;
            err     <= r_err;
            bcd     <= w_dd_nxt[27:12];
            done    <= 1'b1;
            valid   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_exec.sv
// ---------------------------------------------------------------------------
// tb_calc_exec : randomized + directed bench for calc_exec with cycle model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_calc_exec;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        flag = 1'b0;
  logic [5:0]  A = 6'd0;
  logic [5:0]  B = 6'd0;
  logic [1:0]  opcode = 2'd0;
  logic [11:0] result;
  logic        neg;
  logic [5:0]  rem;
  logic        err;
  logic [15:0] bcd;
  logic        busy;
  logic        done;
  logic        valid;

  calc_exec dut (
    .clk    (clk),
    .resetN (resetN),
    .flag   (flag),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .result (result),
    .neg    (neg),
    .rem    (rem),
    .err    (err),
    .bcd    (bcd),
    .busy   (busy),
    .done   (done),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int exp_lat(input int op, input int b);
    return ((op < 2) || (op == 3 && b == 0)) ? 15 : 20;
  endfunction

  function automatic void model_calc(input int a, input int b, input int op,
                                     output int res, output bit ng, output int rm, output bit er);
    res = 0; ng = 0; rm = 0; er = 0;
    case (op)
      0: res = a + b;
      1: begin
        if (a >= b) res = a - b;
        else begin res = b - a; ng = 1; end
      end
      2: res = a * b;
      default: begin
        if (b == 0) er = 1;
        else begin res = a / b; rm = a % b; end
      end
    endcase
  endfunction

  // Reference: flag history, then a countdown from capture to completion.
  bit          m_h1 = 0, m_h2 = 0, m_h3 = 0, m_start = 0;
  int          m_left = 0;
  bit          m_busy = 0, m_done = 0, m_valid = 0, m_neg = 0, m_err = 0;
  logic [11:0] m_result = 12'd0;
  logic [5:0]  m_rem = 6'd0;
  logic [15:0] m_bcd = 16'd0;
  int          p_res = 0, p_rm = 0;
  bit          p_ng = 0, p_er = 0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_h1 = 0; m_h2 = 0; m_h3 = 0; m_left = 0;
      m_busy = 0; m_done = 0; m_valid = 0; m_neg = 0; m_err = 0;
      m_result = 12'd0; m_rem = 6'd0; m_bcd = 16'd0;
    end else begin
      m_start = m_h2 && !m_h3;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_result = 12'(p_res);
          m_neg    = p_ng;
          m_rem    = 6'(p_rm);
          m_err    = p_er;
          m_bcd    = to_bcd(p_res);
          m_done   = 1; m_busy = 0; m_valid = 1;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (m_start) begin
        model_calc(int'(A), int'(B), int'(opcode), p_res, p_ng, p_rm, p_er);
        m_busy  = 1;
        m_valid = 0;
        m_left  = exp_lat(int'(opcode), int'(B)) - 2;
      end
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = flag;
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    n_cmp++;
    if ({result, neg, rem, err, bcd, busy, done, valid} !==
        {m_result, m_neg, m_rem, m_err, m_bcd, m_busy, m_done, m_valid}) begin
      n_bad++;
      $display("FAIL cycle t=%0t got res=%0d neg=%0b rem=%0d err=%0b bcd=%h busy=%0b done=%0b valid=%0b exp res=%0d neg=%0b rem=%0d err=%0b bcd=%h busy=%0b done=%0b valid=%0b",
               $time, result, neg, rem, err, bcd, busy, done, valid,
               m_result, m_neg, m_rem, m_err, m_bcd, m_busy, m_done, m_valid);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Raises flag at a negedge so the next posedge is edge 0; lat = edge index where done is first seen.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic [1:0] op,
                        input int hold, output int lat);
    @(negedge clk);
    A = a; B = b; opcode = op; flag = 1'b1;
    lat = -1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (done && lat < 0) lat = k;
      if (k == hold - 1) flag = 1'b0;
      if (lat >= 0 && k >= hold + 3) break;
    end
    flag = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int lat, d0, hold;
    logic [5:0] ra, rb;
    logic [1:0] rop;

    #1;
    check("reset_result", int'(result), 0);
    check("reset_bcd", int'(bcd), 0);
    check("reset_busy_done_valid", int'({busy, done, valid, neg, err}), 0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(posedge clk);

    run_op(6'd63, 6'd63, 2'b00, 4, lat);
    check("add_latency", lat, 15);
    check("add_result", int'(result), 126);
    check("add_bcd", int'(bcd), 16'h0126);
    check("add_neg", int'(neg), 0);
    check("add_valid", int'(valid), 1);

    run_op(6'd5, 6'd9, 2'b01, 4, lat);
    check("subneg_result", int'(result), 4);
    check("subneg_neg", int'(neg), 1);
    check("subneg_bcd", int'(bcd), 16'h0004);

    run_op(6'd20, 6'd20, 2'b01, 3, lat);
    check("subzero_result", int'(result), 0);
    check("subzero_neg", int'(neg), 0);

    run_op(6'd63, 6'd63, 2'b10, 5, lat);
    check("mul_latency", lat, 20);
    check("mul_result", int'(result), 3969);
    check("mul_bcd", int'(bcd), 16'h3969);

    run_op(6'd50, 6'd7, 2'b11, 4, lat);
    check("div_latency", lat, 20);
    check("div_result", int'(result), 7);
    check("div_rem", int'(rem), 1);
    check("div_bcd", int'(bcd), 16'h0007);

    run_op(6'd50, 6'd0, 2'b11, 4, lat);
    check("div0_latency", lat, 15);
    check("div0_err", int'(err), 1);
    check("div0_result_rem", int'({result, rem}), 0);
    check("div0_bcd", int'(bcd), 0);

    // Re-raise flag during CONV of a multiply: must not start a second run.
    @(negedge clk);
    A = 6'd63; B = 6'd63; opcode = 2'b10; flag = 1'b1;
    d0 = done_cnt;
    repeat (12) @(posedge clk);
    #1 flag = 1'b0;
    repeat (3) @(posedge clk);
    #1 flag = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("busy_restart_dones", done_cnt - d0, 1);
    check("busy_restart_idle", int'(busy), 0);
    flag = 1'b0;
    repeat (4) @(posedge clk);

    // Reset at edge 5 of a multiply, flag held high through release.
    @(negedge clk);
    A = 6'd63; B = 6'd63; opcode = 2'b10; flag = 1'b1;
    repeat (6) @(posedge clk);
    #1 resetN = 1'b0;
    @(negedge clk);
    check("rstmid_result", int'(result), 0);
    check("rstmid_bcd", int'(bcd), 0);
    check("rstmid_flags", int'({busy, done, valid, neg, err}), 0);
    @(negedge clk);
    resetN = 1'b1;
    d0 = done_cnt;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done && lat < 0) lat = k;
      if (lat >= 0) break;
    end
    check("rstrel_latency", lat, 20);
    check("rstrel_result", int'(result), 3969);
    repeat (20) @(posedge clk);
    #1;
    check("rstrel_one_run", done_cnt - d0, 1);
    flag = 1'b0;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      ra   = 6'($urandom_range(0, 63));
      rb   = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      rop  = 2'($urandom_range(0, 3));
      hold = int'($urandom_range(3, 8));
      run_op(ra, rb, rop, hold, lat);
      check("rand_latency", lat, exp_lat(int'(rop), int'(rb)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
